pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//   Parametrised pipeline register for the MIPS datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Carries a WIDTH-bit payload with a valid/ready handshake, a synchronous flush for
//   branch/hazard squash and a wrapping transfer counter for performance monitoring.
//   Latency is 1 cycle and throughput is 1 word/cycle when downstream is ready.
// PARAMETERS
//   WIDTH       32     payload width in bits (>=1)
//   RESET_VALUE 0      value of out_data after reset (WIDTH bits)
//   COUNT_W     16     width of xfer_count (>=1)
// PORTS
//   clk         in   1        rising-edge clock
//   reset       in   1        asynchronous, active-high reset
//   in_valid    in   1        upstream word present
//   in_ready    out  1        stage can accept a word this cycle
//   in_data     in   WIDTH    upstream payload
//   out_valid   out  1        payload on out_data is valid
//   out_ready   in   1        downstream accepts this cycle
//   out_data    out  WIDTH    registered payload
//   flush       in   1        synchronous squash of all held words
//   xfer_count  out  COUNT_W  number of output transfers, modulo 2^COUNT_W
// BEHAVIOUR
//   - fire_in = in_valid & in_ready; fire_out = out_valid & out_ready (same rising edge).
//   - Reset (async, takes effect immediately): out_valid=0, out_data=RESET_VALUE,
//     xfer_count=0, skid entry empty; in_ready=0 while reset high, 1 first cycle after.
//   - Reset asserted mid-transfer: held words are discarded and no transfer is counted.
//   - Upstream rule: in_data stays stable while in_valid=1 and in_ready=0.
//   - Downstream guarantee: once out_valid=1, out_valid and out_data hold until fire_out.
//   - Base (single entry): in_ready = ~out_valid | out_ready (combinational).
//     Edge: if fire_in then out_data<=in_data, out_valid<=1;
//     else if fire_out then out_valid<=0.
//     out_data is not cleared when out_valid falls.
//   - Simultaneous fire_in and fire_out: new word replaces the old one; out_valid stays 1.
//   - flush=1 has priority over everything: next edge out_valid=0, skid emptied,
//     fire_in in that cycle is dropped. out_data is unchanged.
//     fire_out in that cycle still completes and is counted.
//   - xfer_count increments by 1 on each fire_out and wraps 2^COUNT_W-1 -> 0.
//     flush does not clear it.
// CONFIGURATION
//   PIPE_SKID_EN defined: two-entry skid buffer (main + skid register).
//     - in_ready is a flop equal to ~skid_valid; no combinational path from out_ready.
//     - fire_in while out_valid=1 and out_ready=0 writes in_data to skid; skid_valid<=1.
//     - fire_out with skid_valid=1: main<=skid, skid_valid<=0, out_valid stays 1.
//     - fire_in while skid_valid=1 cannot occur (in_ready=0).
//     - Ordering is strictly FIFO; latency (empty stage) is still 1 cycle.
//     - Reset value of in_ready flop: 0 during reset, 1 after.
//   PIPE_SKID_EN undefined: base single-entry behaviour; no skid storage synthesised.
// TESTING
//   1 Reset: assert reset with in_valid=1, in_data=32'hDEAD_BEEF
//     -> out_valid=0, out_data=0, xfer_count=0, in_ready=0; release -> in_ready=1.
//   2 Stream: out_ready=1, send 1,2,3 on consecutive cycles
//     -> out_data 1,2,3 one cycle later each, xfer_count=3, no bubbles.
//   3 Backpressure: hold out_ready=0 after word 5 is accepted, offer 6
//     -> out_data=5 held stable. Base: in_ready=0.
//     Skid: 6 accepted, then in_ready=0; out_ready=1 -> 5 then 6.
//   4 Flush: stage holds 7, upstream offers 8, flush=1, out_ready=0
//     -> next cycle out_valid=0, 8 lost, xfer_count unchanged.
//   5 Counter wrap: COUNT_W=2, perform 5 transfers -> xfer_count 1,2,3,0,1.
//   6 Reset mid-operation (skid build): skid full with 9/10, assert reset
//     -> out_valid=0 at once; after release send 11 -> output is 11 only.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Parametrised pipeline register for the MIPS datapath (IF/ID, ID/EX,
//   EX/MEM, MEM/WB). Moves a WIDTH-bit payload with a valid/ready handshake,
//   one cycle of latency and one word per cycle of throughput while the
//   downstream side is ready. A synchronous flush squashes every held word,
//   and a wrapping counter tallies output transfers for performance monitoring.
//
// Build option
//   PIPE_SKID_EN  defined   : two-entry skid buffer (main + skid register).
//                             in_ready is registered, so there is no
//                             combinational path from out_ready to in_ready.
//                 undefined : single-entry stage with
//                             in_ready = ~out_valid | out_ready.
//                             No skid storage is built.
//
// Parameters
//   WIDTH        payload width in bits (>=1)
//   RESET_VALUE  value of out_data after reset
//   COUNT_W      width of xfer_count (>=1)
//
// Ports
//   clk          in   1        rising-edge clock
//   reset        in   1        asynchronous, active-high reset
//   in_valid     in   1        upstream word present
//   in_ready     out  1        stage can accept a word this cycle
//   in_data      in   WIDTH    upstream payload
//   out_valid    out  1        payload on out_data is valid
//   out_ready    in   1        downstream accepts this cycle
//   out_data     out  WIDTH    registered payload
//   flush        in   1        synchronous squash of all held words
//   xfer_count   out  COUNT_W  output transfers, modulo 2^COUNT_W
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int unsigned      COUNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   input  logic               flush,
   output logic [COUNT_W-1:0] xfer_count
);

   // The transfer counter wraps naturally from all-ones back to zero.
   function automatic logic [COUNT_W-1:0] count_wrap(input logic [COUNT_W-1:0] c);
      return c + COUNT_W'(1);
   endfunction

   logic             fire_in;
   logic             fire_out;
   logic             vld_nxt;
   logic [WIDTH-1:0] data_nxt;

   assign fire_in  = in_valid & in_ready;
   assign fire_out = out_valid & out_ready;

`ifdef PIPE_SKID_EN

   logic             skid_vld_p1;
   logic             skid_vld_nxt;
   logic [WIDTH-1:0] skid_data_p1;
   logic [WIDTH-1:0] skid_data_nxt;
   logic             rdy_p1;

   // The stage accepts whenever the skid slot is free; the flag is
   // registered so out_ready never reaches in_ready combinationally.
   assign in_ready = rdy_p1;

   always_comb begin
      vld_nxt       = out_valid;
      data_nxt      = out_data;
      skid_vld_nxt  = skid_vld_p1;
      skid_data_nxt = skid_data_p1;
      if (flush) begin
         // Squash both entries; an accepted word in this cycle is dropped.
         vld_nxt      = 1'b0;
         skid_vld_nxt = 1'b0;
      end else if (fire_out) begin
         if (skid_vld_p1) begin
            // Older skid word moves up; in_ready was low, so no fire_in.
            data_nxt     = skid_data_p1;
            skid_vld_nxt = 1'b0;
         end else if (fire_in) begin
            data_nxt = in_data;
         end else begin
            vld_nxt = 1'b0;
         end
      end else if (fire_in) begin
         if (out_valid) begin
            // Main entry is stalled: park the new word behind it.
            skid_data_nxt = in_data;
            skid_vld_nxt  = 1'b1;
         end else begin
            data_nxt = in_data;
            vld_nxt  = 1'b1;
         end
      end
   end

   // ---- stage boundary: skid control registers ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         skid_vld_p1 <= 1'b0;
         rdy_p1      <= 1'b0;
      end else begin
         skid_vld_p1 <= skid_vld_nxt;
         rdy_p1      <= ~skid_vld_nxt;
      end
   end

   // ---- stage boundary: skid payload register (no reset on data) ----
   always_ff @(posedge clk) begin
      skid_data_p1 <= skid_data_nxt;
   end

`else

   // Single entry: room exists if empty or the held word leaves this edge.
   // Held low during reset so nothing is offered as accepted.
   assign in_ready = ~reset & (~out_valid | out_ready);

   always_comb begin
      vld_nxt  = out_valid;
      data_nxt = out_data;
      if (flush) begin
         vld_nxt = 1'b0;
      end else if (fire_in) begin
         // Also covers simultaneous fire_out: the new word replaces the old.
         vld_nxt  = 1'b1;
         data_nxt = in_data;
      end else if (fire_out) begin
         vld_nxt = 1'b0;
      end
   end

`endif

   // ---- stage boundary: main output register and transfer counter ----
   // out_data keeps its last value when out_valid drops, and flush leaves it
   // untouched. A transfer completing alongside flush is still counted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_data   <= RESET_VALUE;
         xfer_count <= '0;
      end else begin
         out_valid <= vld_nxt;
         out_data  <= data_nxt;
         if (fire_out) begin
            xfer_count <= count_wrap(xfer_count);
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

   localparam int CW = 2;
`ifdef PIPE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_data;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_data;
   logic          flush;
   logic [CW-1:0] xfer_count;

   pipe_stage_reg #(
      .WIDTH       (32),
      .RESET_VALUE (32'h0),
      .COUNT_W     (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .flush      (flush),
      .xfer_count (xfer_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Scoreboard: words the stage is expected to deliver, oldest first.
   logic [31:0]   sb_q[$];
   logic [CW-1:0] cnt_m;
   bit            rdy_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive after the falling edge, check, then advance the
   // scoreboard on the rising edge.
   task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
      logic exp_rdy;
      logic fire_o;
      logic fire_i;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      #1;
      exp_rdy = SKID ? rdy_m : ((sb_q.size() == 0) || ordy);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(sb_q.size() > 0));
      if (sb_q.size() > 0) chk("out_data", out_data, sb_q[0]);
      chk("xfer_count", 32'(xfer_count), 32'(cnt_m));
      fire_o = (sb_q.size() > 0) && ordy;
      fire_i = iv && exp_rdy;
      @(posedge clk);
      if (fire_o) begin
         void'(sb_q.pop_front());
         cnt_m = cnt_m + 1'b1;
      end
      if (fl) sb_q.delete();
      else if (fire_i) sb_q.push_back(d);
      rdy_m = (sb_q.size() < 2);
      @(negedge clk);
   endtask

   // Assert reset between clock edges; its effect must be immediate.
   task automatic do_reset(input logic iv, input logic [31:0] d);
      reset     = 1'b1;
      in_valid  = iv;
      in_data   = d;
      out_ready = 1'b0;
      flush     = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_xfer_count", 32'(xfer_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      sb_q.delete();
      cnt_m = '0;
      rdy_m = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      @(posedge clk);
      rdy_m = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within budget");
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
      cnt_m     = '0;
      rdy_m     = 1'b0;
      #2;

      // Reset while upstream offers a word.
      do_reset(1'b1, 32'hDEAD_BEEF);

      // Streaming with downstream always ready.
      step(1'b1, 32'd1, 1'b1, 1'b0);
      step(1'b1, 32'd2, 1'b1, 1'b0);
      step(1'b1, 32'd3, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b0);
      chk("stream_count", 32'(xfer_count), 32'd3);
      step(1'b0, 32'd0, 1'b1, 1'b0);

      // Backpressure: 5 held, 6 offered until downstream frees up.
      step(1'b1, 32'd5, 1'b0, 1'b0);
      step(1'b1, 32'd6, 1'b0, 1'b0);
      step(1'b1, 32'd6, 1'b0, 1'b0);
      chk("bp_hold_data", out_data, 32'd5);
      step(1'b1, 32'd6, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b0);

      // Flush with 7 held and 8 offered, downstream stalled.
      step(1'b1, 32'd7, 1'b0, 1'b0);
      step(1'b1, 32'd8, 1'b0, 1'b1);
      chk("flush_hold_data", out_data, 32'd7);
      step(1'b0, 32'd0, 1'b1, 1'b0);

      // Flush while a transfer completes: the transfer still counts.
      step(1'b1, 32'd20, 1'b0, 1'b0);
      step(1'b1, 32'd21, 1'b1, 1'b1);
      step(1'b0, 32'd0, 1'b1, 1'b0);

      // Counter wrap with a 2-bit counter.
      for (int i = 0; i < 5; i++) step(1'b1, 32'd100 + 32'(i), 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b0);

      // Reset with words held (skid full in the two-entry build).
      step(1'b1, 32'd9, 1'b0, 1'b0);
      step(1'b1, 32'd10, 1'b0, 1'b0);
      do_reset(1'b1, 32'd10);
      step(1'b1, 32'd11, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b0);
      chk("post_reset_count", 32'(xfer_count), 32'd1);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
